nanosoc_arbiter_rr_dmem: RTL

Round-robin output-stage arbiter for the DMEM slave port of the nanosoc bus matrix. It decides which of four input stages drives the shared DMEM output stage and replaces the fixed-priority scheme with fair rotation. It keeps fixed-length bursts and locked sequences intact, and tracks per-port wait age so that no requester starves. It drops into the output stage using the same addr_in_port/no_port contract as the existing arbiters.

---
 rtl/nanosoc_ahb_pkg.sv | 36 +++
 rtl/nanosoc_arbiter_rr_dmem_if.sv | 30 +++
 rtl/nanosoc_arb_burst_tracker.sv | 86 ++++++++
 rtl/nanosoc_arbiter_rr_dmem.sv | 134 +++++++++++++
 4 files changed

// File: rtl/nanosoc_ahb_pkg.sv
// AHB-Lite encodings shared across the nanosoc bus matrix arbiters.
package nanosoc_ahb_pkg;

    typedef enum logic [1:0] {
        TRN_IDLE   = 2'b00,
        TRN_BUSY   = 2'b01,
        TRN_NONSEQ = 2'b10,
        TRN_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BST_SINGLE = 3'd0,
        BST_INCR   = 3'd1,
        BST_WRAP4  = 3'd2,
        BST_INCR4  = 3'd3,
        BST_WRAP8  = 3'd4,
        BST_INCR8  = 3'd5,
        BST_WRAP16 = 3'd6,
        BST_INCR16 = 3'd7
    } hburst_e;

    localparam int unsigned NUM_PORTS = 4;

    // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst_e'(hburst))
            BST_INCR16, BST_WRAP16: beats = 4'd15;
            BST_INCR8,  BST_WRAP8:  beats = 4'd7;
            BST_INCR4,  BST_WRAP4:  beats = 4'd3;
            default:                beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/nanosoc_arbiter_rr_dmem_if.sv
// Output-stage side signals of the DMEM arbiter: requests, bus status in, port selection out.
interface nanosoc_arbiter_rr_dmem_if;

    logic       req_port0;
    logic       req_port1;
    logic       req_port2;
    logic       req_port3;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic       starve_evt;
    logic [7:0] grant_count;

    modport master (
        output req_port0, req_port1, req_port2, req_port3,
        output HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, starve_evt, grant_count
    );

    modport slave (
        input  req_port0, req_port1, req_port2, req_port3,
        input  HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, starve_evt, grant_count
    );

endinterface

// File: rtl/nanosoc_arb_burst_tracker.sv
// Tracks fixed-length bursts on the output stage and reports whether the next cycle must hold the grant.
module nanosoc_arb_burst_tracker
    import nanosoc_ahb_pkg::*;
#(
    parameter int EARLY_TERM_MAX = 2
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       next_hold
);

    localparam int ET_W = (EARLY_TERM_MAX < 1) ? 1 : $clog2(EARLY_TERM_MAX + 1);

    logic [3:0]      burst_cnt;
    logic [3:0]      next_cnt;
    logic            burst_hold;
    logic [ET_W-1:0] et_cnt;
    logic [ET_W-1:0] next_et;
    htrans_e         trans;

    assign trans = htrans_e'(HTRANSM);

    always_comb begin
        next_cnt  = burst_cnt;
        next_hold = burst_hold;
        if (!HSELM) begin
            next_cnt  = '0;
            next_hold = 1'b0;
        end else begin
            case (trans)
                TRN_IDLE: begin
                    next_cnt  = '0;
                    next_hold = 1'b0;
                end
                TRN_BUSY: begin
                    next_cnt  = burst_cnt;
                    next_hold = burst_hold;
                end
                TRN_NONSEQ: begin
                    // A master that keeps abandoning bursts loses its right to hold the port.
                    if (burst_hold && (et_cnt == ET_W'(EARLY_TERM_MAX))) begin
                        next_cnt  = '0;
                        next_hold = 1'b0;
                    end else begin
                        next_cnt  = burst_beats_m1(HBURSTM);
                        next_hold = (next_cnt != 4'd0);
                    end
                end
                TRN_SEQ: begin
                    next_cnt = (burst_cnt == 4'd0) ? 4'd0 : burst_cnt - 4'd1;
                    if (burst_cnt == 4'd1) next_hold = 1'b0;
                end
                default: begin
                    next_cnt  = '0;
                    next_hold = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        next_et = et_cnt;
        if (!next_hold) begin
            next_et = '0;
        end else if (HSELM && (trans == TRN_NONSEQ) && burst_hold) begin
            next_et = et_cnt + ET_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            burst_cnt  <= '0;
            burst_hold <= 1'b0;
            et_cnt     <= '0;
        end else if (HREADYM) begin
            burst_cnt  <= next_cnt;
            burst_hold <= next_hold;
            et_cnt     <= next_et;
        end
    end

endmodule

// File: rtl/nanosoc_arbiter_rr_dmem.sv
// Round-robin DMEM output-stage arbiter with burst/lock hold and wait-age starvation override.
module nanosoc_arbiter_rr_dmem
    import nanosoc_ahb_pkg::*;
#(
    parameter int WAIT_W         = 4,
    parameter int MAX_WAIT       = 12,
    parameter int EARLY_TERM_MAX = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    nanosoc_arbiter_rr_dmem_if.slave bus
);

    logic [3:0]        req;
    logic [3:0]        starved;
    logic              next_hold;
    logic              arb_pt;
    logic [1:0]        rr_ptr;
    logic [WAIT_W-1:0] wait_age [NUM_PORTS];

    logic [1:0] addr_q;
    logic       nop_q;
    logic       starve_q;
    logic [7:0] gcnt_q;

    logic       grant_vld;
    logic [1:0] grant_idx;
    logic       starve_win;
    logic [1:0] addr_nxt;
    logic       nop_nxt;

    assign req = {bus.req_port3, bus.req_port2, bus.req_port1, bus.req_port0};

    nanosoc_arb_burst_tracker #(
        .EARLY_TERM_MAX(EARLY_TERM_MAX)
    ) u_burst (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HREADYM  (bus.HREADYM),
        .HSELM    (bus.HSELM),
        .HTRANSM  (bus.HTRANSM),
        .HBURSTM  (bus.HBURSTM),
        .next_hold(next_hold)
    );

    // Locked sequences and unfinished bursts keep the current owner, starved or not.
    assign arb_pt = !bus.HMASTLOCKM && !next_hold;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int p = 3; p >= 0; p--) begin
            if (v[p]) idx = 2'(p);
        end
        return idx;
    endfunction

    // First requester after ptr in rotation; ptr itself is considered last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = ptr;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (r[cand]) idx = cand;
        end
        return idx;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            starved[p] = req[p] && (wait_age[p] >= WAIT_W'(MAX_WAIT));
        end
    end

    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = addr_q;
        starve_win = 1'b0;
        addr_nxt   = addr_q;
        nop_nxt    = nop_q;
        if (arb_pt) begin
            if (|starved) begin
                grant_vld  = 1'b1;
                grant_idx  = lowest_idx(starved);
                starve_win = 1'b1;
            end else if (|req) begin
                grant_vld = 1'b1;
                grant_idx = rr_pick(req, rr_ptr);
            end else if (bus.HSELM && (bus.HTRANSM != TRN_IDLE)) begin
                nop_nxt = nop_q;
            end else if (bus.HSELM) begin
                nop_nxt = 1'b0;
            end else begin
                nop_nxt = 1'b1;
            end
        end
        if (grant_vld) begin
            addr_nxt = grant_idx;
            nop_nxt  = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q   <= 2'd0;
            nop_q    <= 1'b1;
            starve_q <= 1'b0;
            gcnt_q   <= 8'd0;
            rr_ptr   <= 2'd3;
            for (int p = 0; p < NUM_PORTS; p++) wait_age[p] <= '0;
        end else if (bus.HREADYM) begin
            addr_q   <= addr_nxt;
            nop_q    <= nop_nxt;
            starve_q <= starve_win;
            if (grant_vld) rr_ptr <= grant_idx;
            if (grant_vld && ((grant_idx != addr_q) || nop_q)) gcnt_q <= gcnt_q + 8'd1;
            // The port that owns the output stage after this cycle is not waiting.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!req[p] || (!nop_nxt && (addr_nxt == 2'(p)))) begin
                    wait_age[p] <= '0;
                end else if (wait_age[p] != {WAIT_W{1'b1}}) begin
                    wait_age[p] <= wait_age[p] + WAIT_W'(1);
                end
            end
        end
    end

    assign bus.addr_in_port = addr_q;
    assign bus.no_port      = nop_q;
    assign bus.starve_evt   = starve_q;
    assign bus.grant_count  = gcnt_q;

endmodule
